// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
//   arb_state_t : arbitration FSM state (normal arbitration / DMA burst lock)
//   owner_t     : which requester drives the data_mem port in the current cycle
package dmem_arb_pkg;

  typedef enum logic {
    ARB,
    DMA_LOCK
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DMA
  } owner_t;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating starvation counter.
// Counts cycles in which a requester was denied and flags when the count
// has reached MAX, so the arbiter can force a grant.
//   clk, rst : clock / asynchronous active-low reset
//   inc      : denied this cycle (count up, saturating at MAX)
//   clr      : granted or idle this cycle (return to zero, wins over inc)
//   sat      : counter currently equals MAX
module dmem_starve_ctr #(
  parameter int unsigned MAX   = 4,
  parameter int unsigned CNT_W = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign sat = (cnt_q == CNT_W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the CPU MEM stage and a DMA/debug
// loader port. CPU wins by default; a starvation counter forces a DMA grant
// after STARVE_MAX consecutive denials, and DMA may hold the memory for a
// bounded burst (at most LOCK_MAX cycles including the entry cycle).
//   clk, rst                 : clock / asynchronous active-low reset
//   cpu_req/we/addr/wdata    : CPU MEM-stage access
//   cpu_rdata                : CPU load data (combinational, zero when not granted)
//   cpu_stall                : CPU request not granted this cycle
//   dma_req/we/lock/addr/wdata : DMA access and burst-ownership request
//   dma_gnt                  : DMA access performed this cycle
//   dma_rvalid, dma_rdata    : registered DMA read return
//   mem_we/addr/wd, mem_rd   : data_mem port (combinational read)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned LOCK_MAX   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
  localparam int unsigned LOCK_W   = $clog2(LOCK_MAX);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_MAX - 1);

  arb_state_t        state_q, state_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              dma_rvalid_q, dma_rvalid_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic   force_dma;
  logic   cpu_gnt;
  logic   dma_gnt_c;
  owner_t owner;

  // Starvation tracking: any denied DMA cycle counts, a grant or an idle
  // DMA port restarts the count.
  dmem_starve_ctr #(
    .MAX   (STARVE_MAX),
    .CNT_W (STARVE_W)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (dma_req & ~dma_gnt_c),
    .clr (dma_gnt_c | ~dma_req),
    .sat (force_dma)
  );

  // Grant decision and next-state logic.
  always_comb begin
    dma_gnt_c  = 1'b0;
    cpu_gnt    = 1'b0;
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;

    case (state_q)
      ARB: begin
        dma_gnt_c  = dma_req & (~cpu_req | force_dma);
        cpu_gnt    = cpu_req & ~dma_gnt_c;
        lock_cnt_d = '0;
        if (dma_gnt_c && dma_lock) begin
          state_d    = DMA_LOCK;
          lock_cnt_d = LOCK_W'(1);
        end
      end
      DMA_LOCK: begin
        dma_gnt_c = dma_req;
        cpu_gnt   = 1'b0;
        // The cycle that ends the burst still belongs to DMA; CPU gets the
        // port back on the following cycle because starve_cnt is then zero.
        if (!dma_lock || !dma_req || (lock_cnt_q == LOCK_LAST)) begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = ARB;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Memory port ownership and mux; an ungranted request never touches data_mem.
  always_comb begin
    owner = OWN_NONE;
    if (dma_gnt_c) begin
      owner = OWN_DMA;
    end else if (cpu_gnt) begin
      owner = OWN_CPU;
    end
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    case (owner)
      OWN_CPU: begin
        mem_we   = cpu_we;
        mem_addr = cpu_addr;
        mem_wd   = cpu_wdata;
      end
      OWN_DMA: begin
        mem_we   = dma_we;
        mem_addr = dma_addr;
        mem_wd   = dma_wdata;
      end
      default: begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
      end
    endcase
  end

  // DMA read return is registered; rdata holds between reads.
  always_comb begin
    dma_rvalid_d = dma_gnt_c & ~dma_we;
    dma_rdata_d  = dma_rdata_q;
    if (dma_gnt_c && !dma_we) begin
      dma_rdata_d = mem_rd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB;
      lock_cnt_q   <= '0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign dma_gnt    = dma_gnt_c;
  assign cpu_stall  = cpu_req & ~cpu_gnt;
  assign cpu_rdata  = cpu_gnt ? mem_rd : '0;
  assign dma_rvalid = dma_rvalid_q;
  assign dma_rdata  = dma_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline MEM stage (CPU) and a DMA/debug loader port (DMA).
- CPU has default priority. A starvation counter guarantees DMA forward progress.
- A lock FSM lets DMA hold the memory for bounded bursts.
- Sits between the MEM stage and `data_mem`. Drives the CPU pipeline stall.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_MAX, 4, consecutive denied DMA cycles before a forced DMA grant (≥1)
LOCK_MAX, 8, maximum consecutive DMA_LOCK cycles (≥2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; asynchronous, active-low
cpu_req  in  1  CPU MEM-stage access request (load or store)
cpu_we  in  1  CPU write enable
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU store data
cpu_rdata  out  DATA_W  CPU load data, combinational
cpu_stall  out  1  freeze pipeline: CPU request not granted this cycle
dma_req  in  1  DMA access request
dma_we  in  1  DMA write enable
dma_lock  in  1  DMA requests burst ownership
dma_addr  in  ADDR_W  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_gnt  out  1  DMA access performed this cycle
dma_rvalid  out  1  registered DMA read data valid
dma_rdata  out  DATA_W  registered DMA read data
mem_we  out  1  to data_mem write enable
mem_addr  out  ADDR_W  to data_mem address
mem_wd  out  DATA_W  to data_mem write data
mem_rd  in  DATA_W  from data_mem combinational read data

Behaviour:
- Memory model: combinational read, write on rising clk when mem_we=1.
- FSM states are ARB and DMA_LOCK. Reset state is ARB.
- Grant in ARB (combinational from state, counters and current inputs):
  - force_dma = (starve_cnt == STARVE_MAX).
  - dma_gnt = dma_req & (~cpu_req | force_dma).
  - cpu_gnt = cpu_req & ~dma_gnt.
- Grant in DMA_LOCK:
  - dma_gnt = dma_req.
  - cpu_gnt = 0.
- cpu_stall = cpu_req & ~cpu_gnt.
- Memory mux:
  - Granted requester drives mem_addr, mem_wd, and mem_we (= its we).
  - No grant: mem_we=0, mem_addr=0, mem_wd=0.
  - A non-granted write never reaches memory.
- cpu_rdata = mem_rd when cpu_gnt, else 0. Zero added latency; the MEM/WB register captures it.
- DMA read return:
  - dma_rvalid <= dma_gnt & ~dma_we, so it is high one cycle after the granted read.
  - dma_rdata <= mem_rd on a granted read. Otherwise dma_rdata holds its value.
- starve_cnt:
  - Width $clog2(STARVE_MAX+1). Saturates at STARVE_MAX.
  - Increments when dma_req & ~dma_gnt.
  - Clears on dma_gnt or when dma_req=0.
- Transitions:
  - ARB→DMA_LOCK when dma_gnt & dma_lock. lock_cnt <= 1.
  - DMA_LOCK→ARB when ~dma_lock, or ~dma_req, or lock_cnt == LOCK_MAX-1.
  - Otherwise lock_cnt increments.
  - Result: DMA owns at most LOCK_MAX consecutive cycles including the entry cycle.
- After leaving DMA_LOCK:
  - starve_cnt = 0.
  - A pending CPU request wins the next cycle, even if dma_lock is still high.
  - DMA cannot re-enter DMA_LOCK until it is granted again via ARB rules.
- Simultaneous events:
  - Force and lock in the same cycle: DMA is granted and enters DMA_LOCK.
  - Both requests absent: no grant, counters clear.
- Reset (asynchronous, also mid-burst) sets immediately:
  - State ARB; starve_cnt=0; lock_cnt=0.
  - dma_rvalid=0; dma_rdata=0.
  - Combinational outputs follow the reset state: with cpu_req=1, CPU is granted.
  - An in-flight DMA read is dropped with no rvalid.

Decomposition:
- Package dmem_arb_pkg contains:
  - typedef enum logic {ARB, DMA_LOCK} arb_state_t.
  - typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t.
- One sub-module: dmem_starve_ctr, a parameterised saturating counter with inc/clr/sat outputs. Used for starve_cnt.
- FSM, lock counter and mux stay in the top module.

Test Plan:
1. CPU write then read: cpu_req=1, cpu_we=1, addr 0x10, wdata 0xDEADBEEF → mem_we=1, cpu_stall=0. Next cycle read of 0x10 → cpu_rdata=0xDEADBEEF same cycle.
2. DMA-only read of 0x10 → dma_gnt=1 in cycle N; dma_rvalid=1 and dma_rdata=0xDEADBEEF in N+1; dma_rvalid=0 in N+2.
3. Contention (STARVE_MAX=4, both requests held) → CPU granted cycles 0–3; cycle 4 dma_gnt=1 and cpu_stall=1; cycle 5 CPU granted; pattern repeats every 5 cycles.
4. Lock burst (LOCK_MAX=8, dma_lock=1, cpu_req held) → DMA owns exactly 8 consecutive cycles with cpu_stall=1; cycle 9 CPU granted.
5. Reset mid-lock: rst=0 at lock cycle 3 → dma_rvalid=0 and state ARB immediately. After release with both requests, CPU granted first; the earlier DMA read never signals rvalid.
6. Write gating: CPU store to 0x20 (data 0x11111111) issued while DMA forced read → mem_we=0 that cycle; 0x20 unchanged until CPU granted next cycle, then holds 0x11111111.
